seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
Parametrised serial pattern detector for the lab sequential-logic library. It monitors a 1-bit qualified input stream for a runtime-programmable pattern of 1..MAX_LEN bits. Overlapping or non-overlapping matching is selectable. The output is either Mealy (same-cycle) or registered (one cycle later), and a saturating match counter and progress indicator are exposed for display.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
COUNT_WIDTH, 8, width of match counter
OUTPUT_MODE, 0, 0 = Mealy combinational seq_detected, 1 = registered seq_detected
DEFAULT_PATTERN, 8'b0000_0101, pattern loaded at reset (width MAX_LEN)
DEFAULT_LEN, 3, pattern length loaded at reset
DEFAULT_OVERLAP, 1, overlap mode loaded at reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-high reset
data_in  input  1  serial data bit
data_valid  input  1  data_in is sampled only when high
cfg_pattern  input  MAX_LEN  new pattern; bit [len-1] = first bit received, bit [0] = last
cfg_len  input  $clog2(MAX_LEN+1)  new pattern length
cfg_overlap  input  1  1 = overlapping matches allowed
cfg_load  input  1  latch cfg_* on this edge
count_clr  input  1  clear match counter
seq_detected  output  1  match pulse
match_count  output  COUNT_WIDTH  saturating number of matches
count_sat  output  1  high while match_count is all-ones
cfg_err  output  1  sticky: last cfg_load was rejected
state_out  output  $clog2(MAX_LEN+1)  fill level: valid history bits, saturating at MAX_LEN

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-high.
- Reset values: pattern=DEFAULT_PATTERN, len=DEFAULT_LEN, overlap=DEFAULT_OVERLAP, history=0, fill=0, match_count=0, count_sat=0, cfg_err=0, seq_detected=0 in both modes.
- Reset asserted mid-stream discards all partial progress immediately.
- History: shift register hist[MAX_LEN-1:0]; hist[0] holds the newest bit.
- On a valid cycle: hist_next = {hist[MAX_LEN-2:0], data_in}.
- match = data_valid & (fill+1 >= len) & (hist_next[len-1:0] == pattern[len-1:0]). Only the low len bits are compared; the upper bits are ignored.
- Fill update on a valid cycle:
  - no match: fill = min(fill+1, MAX_LEN)
  - match with overlap=1: fill = min(fill+1, MAX_LEN)
  - match with overlap=0: fill = 0, so no bit is reused by the next match
- Cycles with data_valid=0: hist, fill, counter and outputs hold; seq_detected=0.
- OUTPUT_MODE=0: seq_detected = match, combinational in the same cycle as the final bit.
- OUTPUT_MODE=1: seq_detected is a register set to match, so the pulse appears exactly 1 cycle after the final bit.
- Counter: on match, match_count increments, saturating at 2^COUNT_WIDTH-1. count_sat = (match_count == all-ones).
- count_clr alone: match_count=0.
- count_clr together with a match: match_count=1 (clear, then count).
- cfg_load, accepted when 1 <= cfg_len <= MAX_LEN:
  - latch pattern, len and overlap
  - clear hist and fill
  - cfg_err=0
  - match_count is unaffected
- cfg_load, rejected (cfg_len=0 or cfg_len>MAX_LEN): configuration, hist and fill are unchanged; cfg_err=1.
- cfg_err clears only on an accepted load or reset.
- cfg_load with data_valid in the same cycle: cfg_load wins. The data bit is discarded, match is forced to 0, and the new config applies from the next cycle.
- In OUTPUT_MODE=1, a registered pulse already pending from the previous cycle still emits during the load cycle.
- len=1: every valid bit equal to pattern[0] matches, regardless of overlap.
- state_out = fill.

Test Plan:
- Reset defaults (101, overlap), OUTPUT_MODE=0, valid bits 1,0,1,0,1 -> seq_detected high on bits 3 and 5; match_count=2; state_out=5 after the stream.
- cfg_load cfg_len=3, cfg_pattern=101, cfg_overlap=0, then bits 1,0,1,0,1 -> pulse on bit 3 only; match_count=1; state_out=2 after the stream.
- Load cfg_len=4, cfg_pattern=4'b1101 with OUTPUT_MODE=1, then bits 1,1,1,0,1 with data_valid low for 2 cycles between the 3rd and 4th bits -> single pulse one clk after bit 5; fill stalls during the gap.
- cfg_load cfg_len=0, then cfg_len=9 (MAX_LEN=8) -> cfg_err=1 after each; stream 1,0,1 still detected with the default pattern; a following valid load clears cfg_err.
- COUNT_WIDTH=2, len=1, pattern=1, six valid 1s -> match_count reaches 3 and holds with count_sat=1; count_clr asserted on the same cycle as a 1 -> match_count=1.
- Reset asserted asynchronously after bits 1,0 of 101 -> all outputs 0 immediately; subsequent 1 alone gives no pulse; 1,0,1 afterwards gives a pulse.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-programmable pattern of 1..MAX_LEN bits.
// Supports overlap/non-overlap matching, Mealy or registered output, and a saturating match counter.
module seq_detector_param #(
   parameter int                 MAX_LEN         = 8,
   parameter int                 COUNT_WIDTH     = 8,
   parameter bit                 OUTPUT_MODE     = 1'b0,
   parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_0101,
   parameter int                 DEFAULT_LEN     = 3,
   parameter bit                 DEFAULT_OVERLAP = 1'b1,
   localparam int                LW              = $clog2(MAX_LEN+1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   data_in,
   input  logic                   data_valid,
   input  logic [MAX_LEN-1:0]     cfg_pattern,
   input  logic [LW-1:0]          cfg_len,
   input  logic                   cfg_overlap,
   input  logic                   cfg_load,
   input  logic                   count_clr,
   output logic                   seq_detected,
   output logic [COUNT_WIDTH-1:0] match_count,
   output logic                   count_sat,
   output logic                   cfg_err,
   output logic [LW-1:0]          state_out
);

   logic [MAX_LEN-1:0]     pattern_q;
   logic [MAX_LEN-1:0]     hist_q;
   logic [MAX_LEN-1:0]     hist_next;
   logic [MAX_LEN-1:0]     len_mask;
   logic [LW-1:0]          len_q;
   logic [LW-1:0]          fill_q;
   logic [LW-1:0]          fill_inc;
   logic [LW:0]            fill_p1;
   logic                   overlap_q;
   logic                   fill_ok;
   logic                   cfg_ok;
   logic                   match;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   err_q;

   always_comb begin
      hist_next = {hist_q[MAX_LEN-2:0], data_in};
      len_mask  = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < int'(len_q));
      end
      fill_p1  = {1'b0, fill_q} + (LW+1)'(1);
      fill_ok  = (fill_p1 >= {1'b0, len_q});
      fill_inc = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);
      cfg_ok   = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
      // a load in the same cycle swallows the data bit, so it can never complete a match
      match    = data_valid & ~cfg_load & fill_ok &
                 ((hist_next & len_mask) == (pattern_q & len_mask));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pattern_q <= DEFAULT_PATTERN;
         len_q     <= LW'(DEFAULT_LEN);
         overlap_q <= DEFAULT_OVERLAP;
         hist_q    <= '0;
         fill_q    <= '0;
         err_q     <= 1'b0;
      end else if (cfg_load) begin
         if (cfg_ok) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
            hist_q    <= '0;
            fill_q    <= '0;
            err_q     <= 1'b0;
         end else begin
            err_q     <= 1'b1;
         end
      end else if (data_valid) begin
         hist_q <= hist_next;
         // without overlap, restart the fill so no matched bit is reused
         fill_q <= (match && !overlap_q) ? '0 : fill_inc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (count_clr) begin
         count_q <= {{(COUNT_WIDTH-1){1'b0}}, match};
      end else if (match && (count_q != '1)) begin
         count_q <= count_q + COUNT_WIDTH'(1);
      end
   end

   generate
      if (OUTPUT_MODE) begin : g_reg_out
         logic det_q;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               det_q <= 1'b0;
            end else begin
               det_q <= match;
            end
         end
         assign seq_detected = det_q;
      end else begin : g_comb_out
         assign seq_detected = match;
      end
   endgenerate

   assign match_count = count_q;
   assign count_sat   = &count_q;
   assign cfg_err     = err_q;
   assign state_out   = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: a Mealy/8-bit-counter instance and a registered/2-bit-counter
// instance share one stimulus; checked against directed vectors and a queue-based reference model.
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       reset;
   logic       data_in, data_valid, cfg_overlap, cfg_load, count_clr;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;

   logic       det0, det1, sat0, sat1, err0, err1;
   logic [7:0] cnt0;
   logic [1:0] cnt1;
   logic [3:0] st0, st1;

   seq_detector_param #(.MAX_LEN(8), .COUNT_WIDTH(8), .OUTPUT_MODE(1'b0)) u_mealy (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .cfg_load(cfg_load), .count_clr(count_clr), .seq_detected(det0),
      .match_count(cnt0), .count_sat(sat0), .cfg_err(err0), .state_out(st0));

   seq_detector_param #(.MAX_LEN(8), .COUNT_WIDTH(2), .OUTPUT_MODE(1'b1)) u_reg (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .cfg_load(cfg_load), .count_clr(count_clr), .seq_detected(det1),
      .match_count(cnt1), .count_sat(sat1), .cfg_err(err1), .state_out(st1));

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // reference model: bits received since the last clear, plus config and counters
   bit         q[$];
   logic [7:0] m_pat;
   int         m_len;
   bit         m_ovl, m_err, pend;
   int         c8, c2;
   bit         obs_det;

   typedef struct {
      bit         rst_before;
      bit         valid, din, load, clr, covl;
      logic [3:0] clen;
      logic [7:0] cpat;
      bit         e_det;
      int         e_cnt, e_cnt2, e_fill;
      bit         e_err;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act != exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   function automatic vec_t dv(input bit rb, input bit clr, input bit d, input bit ed,
                               input int ec, input int ec2, input int ef, input bit ee);
      vec_t v;
      v.rst_before = rb; v.valid = 1; v.din = d; v.load = 0; v.clr = clr; v.covl = 0;
      v.clen = 0; v.cpat = 0; v.e_det = ed; v.e_cnt = ec; v.e_cnt2 = ec2; v.e_fill = ef;
      v.e_err = ee;
      return v;
   endfunction

   function automatic vec_t ld(input int cl, input logic [7:0] cp, input bit co, input bit d,
                               input int ec, input int ec2, input int ef, input bit ee);
      vec_t v;
      v.rst_before = 0; v.valid = d; v.din = d; v.load = 1; v.clr = 0; v.covl = co;
      v.clen = cl[3:0]; v.cpat = cp; v.e_det = 0; v.e_cnt = ec; v.e_cnt2 = ec2; v.e_fill = ef;
      v.e_err = ee;
      return v;
   endfunction

   function automatic vec_t idle(input bit clr, input int ec, input int ec2, input int ef,
                                 input bit ee);
      vec_t v;
      v.rst_before = 0; v.valid = 0; v.din = 0; v.load = 0; v.clr = clr; v.covl = 0;
      v.clen = 0; v.cpat = 0; v.e_det = 0; v.e_cnt = ec; v.e_cnt2 = ec2; v.e_fill = ef;
      v.e_err = ee;
      return v;
   endfunction

   function automatic void model_reset();
      q.delete();
      m_pat = 8'b0000_0101; m_len = 3; m_ovl = 1; m_err = 0; pend = 0; c8 = 0; c2 = 0;
   endfunction

   function automatic bit model_match();
      if (!data_valid || cfg_load) return 0;
      if (q.size() + 1 < m_len) return 0;
      if (data_in != m_pat[0]) return 0;
      for (int k = 1; k < m_len; k++) begin
         if (q[q.size()-k] != m_pat[k]) return 0;
      end
      return 1;
   endfunction

   function automatic void model_step(input bit m);
      pend = m;
      if (count_clr) begin
         c8 = int'(m); c2 = int'(m);
      end else if (m) begin
         if (c8 < 255) c8++;
         if (c2 < 3) c2++;
      end
      if (cfg_load) begin
         if (cfg_len >= 1 && cfg_len <= 8) begin
            m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap; m_err = 0;
            q.delete();
         end else begin
            m_err = 1;
         end
      end else if (data_valid) begin
         q.push_back(data_in);
         if (m && !m_ovl) q.delete();
         else if (q.size() > 8) void'(q.pop_front());
      end
   endfunction

   function automatic int m_fill();
      return (q.size() > 8) ? 8 : q.size();
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_det0"}, det0, 0);
      chk({tag, "_det1"}, det1, 0);
      chk({tag, "_cnt0"}, cnt0, 0);
      chk({tag, "_cnt1"}, cnt1, 0);
      chk({tag, "_sat1"}, sat1, 0);
      chk({tag, "_err0"}, err0, 0);
      chk({tag, "_st0"}, st0, 0);
      chk({tag, "_st1"}, st1, 0);
   endtask

   // called just after a rising edge: asserts reset between edges and checks it acts at once
   task automatic async_reset();
      data_valid = 0; data_in = 0; cfg_load = 0; count_clr = 0; cfg_len = 0;
      cfg_pattern = 0; cfg_overlap = 0;
      #2 reset = 1;
      #1 check_reset_outputs("async_rst");
      @(posedge clk); #1;
      reset = 0;
      model_reset();
   endtask

   task automatic apply(input bit v, input bit d, input bit l, input logic [3:0] cl,
                        input logic [7:0] cp, input bit co, input bit cr);
      bit m;
      data_valid = v; data_in = d; cfg_load = l; cfg_len = cl; cfg_pattern = cp;
      cfg_overlap = co; count_clr = cr;
      #1;
      m = model_match();
      obs_det = det0;
      chk("mealy_det", det0, int'(m));
      chk("reg_det_pending", det1, int'(pend));
      model_step(m);
      @(posedge clk); #1;
      chk("reg_det", det1, int'(pend));
      chk("cnt8", cnt0, c8);
      chk("sat8", sat0, int'(c8 == 255));
      chk("cnt2", cnt1, c2);
      chk("sat2", sat1, int'(c2 == 3));
      chk("fill_mealy", st0, m_fill());
      chk("fill_reg", st1, m_fill());
      chk("err_mealy", err0, int'(m_err));
      chk("err_reg", err1, int'(m_err));
   endtask

   initial begin
      reset = 1; data_in = 0; data_valid = 0; cfg_load = 0; count_clr = 0;
      cfg_len = 0; cfg_pattern = 0; cfg_overlap = 0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      check_reset_outputs("reset");
      reset = 0;

      // defaults 101 overlap, then non-overlap reload, then len 4 with a valid gap
      tbl.push_back(dv(0,0,1, 0, 0,0,1, 0));
      tbl.push_back(dv(0,0,0, 0, 0,0,2, 0));
      tbl.push_back(dv(0,0,1, 1, 1,1,3, 0));
      tbl.push_back(dv(0,0,0, 0, 1,1,4, 0));
      tbl.push_back(dv(0,0,1, 1, 2,2,5, 0));
      tbl.push_back(ld(3, 8'b101, 0, 0, 2,2,0, 0));
      tbl.push_back(dv(0,0,1, 0, 2,2,1, 0));
      tbl.push_back(dv(0,0,0, 0, 2,2,2, 0));
      tbl.push_back(dv(0,0,1, 1, 3,3,0, 0));
      tbl.push_back(dv(0,0,0, 0, 3,3,1, 0));
      tbl.push_back(dv(0,0,1, 0, 3,3,2, 0));
      tbl.push_back(ld(4, 8'b1101, 1, 0, 3,3,0, 0));
      tbl.push_back(dv(0,0,1, 0, 3,3,1, 0));
      tbl.push_back(dv(0,0,1, 0, 3,3,2, 0));
      tbl.push_back(dv(0,0,1, 0, 3,3,3, 0));
      tbl.push_back(idle(0, 3,3,3, 0));
      tbl.push_back(idle(0, 3,3,3, 0));
      tbl.push_back(dv(0,0,0, 0, 3,3,4, 0));
      tbl.push_back(dv(0,0,1, 1, 4,3,5, 0));
      tbl.push_back(ld(3, 8'b101, 1, 1, 4,3,0, 0));
      // reset, partial 1,0, async reset, then 1 alone and 1,0,1
      tbl.push_back(dv(1,0,1, 0, 0,0,1, 0));
      tbl.push_back(dv(0,0,0, 0, 0,0,2, 0));
      tbl.push_back(dv(1,0,1, 0, 0,0,1, 0));
      tbl.push_back(dv(0,0,0, 0, 0,0,2, 0));
      tbl.push_back(dv(0,0,1, 1, 1,1,3, 0));
      // rejected loads keep the default pattern running
      tbl.push_back(ld(0, 8'b0, 0, 0, 1,1,3, 1));
      tbl.push_back(ld(9, 8'b101, 1, 0, 1,1,3, 1));
      tbl.push_back(dv(0,0,1, 0, 1,1,4, 1));
      tbl.push_back(dv(0,0,0, 0, 1,1,5, 1));
      tbl.push_back(dv(0,0,1, 1, 2,2,6, 1));
      tbl.push_back(ld(1, 8'b1, 0, 0, 2,2,0, 0));
      // len 1, counter saturation on the 2-bit instance, clear with and without a match
      tbl.push_back(idle(1, 0,0,0, 0));
      tbl.push_back(dv(0,0,1, 1, 1,1,0, 0));
      tbl.push_back(dv(0,0,1, 1, 2,2,0, 0));
      tbl.push_back(dv(0,0,1, 1, 3,3,0, 0));
      tbl.push_back(dv(0,0,1, 1, 4,3,0, 0));
      tbl.push_back(dv(0,0,1, 1, 5,3,0, 0));
      tbl.push_back(dv(0,0,1, 1, 6,3,0, 0));
      tbl.push_back(dv(0,0,0, 0, 6,3,1, 0));
      tbl.push_back(dv(0,1,1, 1, 1,1,0, 0));
      tbl.push_back(idle(1, 0,0,0, 0));

      foreach (tbl[i]) begin
         if (tbl[i].rst_before) async_reset();
         apply(tbl[i].valid, tbl[i].din, tbl[i].load, tbl[i].clen, tbl[i].cpat,
               tbl[i].covl, tbl[i].clr);
         chk($sformatf("vec%0d_det", i), obs_det, tbl[i].e_det);
         chk($sformatf("vec%0d_rdet", i), det1, tbl[i].e_det);
         chk($sformatf("vec%0d_cnt", i), cnt0, tbl[i].e_cnt);
         chk($sformatf("vec%0d_cnt2", i), cnt1, tbl[i].e_cnt2);
         chk($sformatf("vec%0d_sat2", i), sat1, int'(tbl[i].e_cnt2 == 3));
         chk($sformatf("vec%0d_fill", i), st0, tbl[i].e_fill);
         chk($sformatf("vec%0d_err", i), err0, tbl[i].e_err);
      end

      // random traffic against the model, short patterns so matches are frequent
      for (int n = 0; n < 1500; n++) begin
         logic [3:0] cl;
         cl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
         apply($urandom_range(0, 9) != 0, 1'($urandom), $urandom_range(0, 39) == 0, cl,
               8'($urandom), 1'($urandom), $urandom_range(0, 59) == 0);
      end

      // long run of matches to saturate the 8-bit counter
      apply(0, 0, 1, 4'd1, 8'b1, 1, 1);
      for (int n = 0; n < 260; n++) apply(1, 1, 0, 4'd0, 8'd0, 0, 0);
      chk("sat8_final", sat0, 1);
      chk("cnt8_final", cnt0, 255);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
